// File: rtl/clos_cm_sync_alloc.sv
// clos_cm_sync_alloc -- clocked central-module port allocator for the Clos SDM router.
//
// Each of P input links (S, W, N, E, L) presents a one-hot target vector.
// Every output link has its own round-robin arbiter with a small
// IDLE -> GRANTED -> RECOVER -> IDLE state machine. A grant is held until
// its owner withdraws. It then spends one RECOVER cycle (return-to-zero)
// before the output can be arbitrated again.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   req   [i*P +: P] target vector of input i (one-hot or zero)
//   ack   ack[i] = input i holds a grant
//   cfg   [o*P +: P] one-hot select of the input driving output o
//   busy  busy[o] = output o is GRANTED or RECOVER
//   err   err[i] = input i presented a multi-hot or illegal request last cycle
//
// All outputs are registered.

// Per-output arbiter and state machine.
//   cand  inputs eligible to win this output this cycle
//   keep  inputs whose request is exactly this output
//   cfg   registered one-hot owner (zero unless GRANTED)
//   take  owner chosen at this edge (IDLE only)
//   stay  owner that keeps its grant through this edge
//   busy  registered GRANTED-or-RECOVER flag
module clos_cm_out_arb #(
    parameter int P  = 5,
    parameter int PW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] cand,
    input  logic [P-1:0] keep,
    output logic [P-1:0] cfg,
    output logic [P-1:0] take,
    output logic [P-1:0] stay,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, GRANTED, RECOVER} state_t;

    state_t        state;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [P-1:0]  win;
    logic          found;
    int            idx;

    // Round-robin search starting at ptr, wrapping modulo P.
    always_comb begin
        win     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int j = 0; j < P; j++) begin
            idx = int'(ptr) + j;
            if (idx >= P) idx = idx - P;
            if (!found && cand[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                ptr_nxt  = (idx == P-1) ? '0 : PW'(idx + 1);
            end
        end
    end

    assign take = (state == IDLE)    ? win          : '0;
    assign stay = (state == GRANTED) ? (cfg & keep) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cfg   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= GRANTED;
                    cfg   <= win;
                    busy  <= 1'b1;
                    ptr   <= ptr_nxt;
                end
                GRANTED: if (stay == '0) begin
                    // Owner withdrew or retargeted; busy stays up through RECOVER.
                    state <= RECOVER;
                    cfg   <= '0;
                end
                RECOVER: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cfg   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

module clos_cm_sync_alloc #(
    parameter int             P     = 5,
    parameter logic [P*P-1:0] ALLOW = 25'h1FF_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [P*P-1:0] req,
    output logic [P-1:0]   ack,
    output logic [P*P-1:0] cfg,
    output logic [P-1:0]   busy,
    output logic [P-1:0]   err
);
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    // Index convention: rq[i][o] is input i asking for output o,
    // cand/keep/cfg_s/take/stay are [o][i].
    logic [P-1:0][P-1:0] rq, alw, cand, keep, cfg_s, take, stay;
    logic [P-1:0]        valid, bad, ack_nxt;

    assign rq  = req;
    assign alw = ALLOW;
    assign cfg = cfg_s;

    always_comb begin
        valid   = '0;
        bad     = '0;
        cand    = '0;
        keep    = '0;
        ack_nxt = '0;
        for (int i = 0; i < P; i++) begin
            valid[i] = (rq[i] != '0) && ((rq[i] & (rq[i] - P'(1))) == '0)
                       && ((rq[i] & alw[i]) != '0);
            bad[i]   = (rq[i] != '0) && !valid[i];
        end
        for (int o = 0; o < P; o++) begin
            for (int i = 0; i < P; i++) begin
                // An input already holding a grant never competes elsewhere.
                cand[o][i] = valid[i] && rq[i][o] && !ack[i];
                keep[o][i] = (rq[i] == (P'(1) << o));
                ack_nxt[i] = ack_nxt[i] | take[o][i] | stay[o][i];
            end
        end
    end

    for (genvar o = 0; o < P; o++) begin : g_out
        clos_cm_out_arb #(.P(P), .PW(PW)) u_arb (
            .clk  (clk),
            .rst  (rst),
            .cand (cand[o]),
            .keep (keep[o]),
            .cfg  (cfg_s[o]),
            .take (take[o]),
            .stay (stay[o]),
            .busy (busy[o])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack <= '0;
            err <= '0;
        end else begin
            ack <= ack_nxt;
            err <= bad;
        end
    end
endmodule

// File: tb/tb_clos_cm_sync_alloc.sv
// Directed bench for clos_cm_sync_alloc. S->S is made illegal through ALLOW;
// every other turn is legal. A cycle table covers reset, round-robin
// contention, illegal requests, parallel grants, retargeting and mid-operation
// reset. A hand-written sequence checks withdraw-to-regrant latency, and a
// negedge monitor checks the structural invariants every cycle.
module tb_clos_cm_sync_alloc;
    localparam int P  = 5;
    localparam int NN = P*P;

    logic          clk = 1'b0;
    logic          rst;
    logic [NN-1:0] req;
    logic [P-1:0]  ack, busy, err;
    logic [NN-1:0] cfg;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    clos_cm_sync_alloc #(.P(P), .ALLOW(25'h1FF_FFFE)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .cfg(cfg), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NN-1:0] req;
        logic [P-1:0]  ack;
        logic [NN-1:0] cfg;
        logic [P-1:0]  busy;
        logic [P-1:0]  err;
    } vec_t;

    vec_t tv[$];

    // r(i,o): input i requests output o.  c(o,i): output o driven by input i.
    function automatic logic [NN-1:0] r(int i, int o);
        logic [NN-1:0] v;
        v = '0;
        v[i*P+o] = 1'b1;
        return v;
    endfunction

    function automatic logic [NN-1:0] c(int o, int i);
        logic [NN-1:0] v;
        v = '0;
        v[o*P+i] = 1'b1;
        return v;
    endfunction

    task automatic add(input logic rs, input logic [NN-1:0] rq, input logic [P-1:0] a,
                       input logic [NN-1:0] cf, input logic [P-1:0] b, input logic [P-1:0] e);
        vec_t v;
        v.rst = rs; v.req = rq; v.ack = a; v.cfg = cf; v.busy = b; v.err = e;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [NN-1:0] act, input logic [NN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic rs, input logic [NN-1:0] rq);
        @(negedge clk);
        rst = rs;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [P-1:0] orv, col;
            orv = '0;
            for (int o = 0; o < P; o++) begin
                logic [P-1:0] s;
                s = cfg[o*P +: P];
                orv = orv | s;
                n_chk++;
                if ($countones(s) > 1 || (!busy[o] && s != '0)) begin
                    n_fail++;
                    $display("FAIL inv_slice out %0d: cfg %b busy %b", o, s, busy[o]);
                end
            end
            for (int i = 0; i < P; i++) begin
                col = '0;
                for (int o = 0; o < P; o++) col[o] = cfg[o*P+i];
                n_chk++;
                if ($countones(col) > 1) begin
                    n_fail++;
                    $display("FAIL inv_input in %0d: appears in slices %b", i, col);
                end
            end
            n_chk++;
            if (ack !== orv) begin
                n_fail++;
                $display("FAIL inv_ack: got %b expected %b", ack, orv);
            end
        end
    end

    initial begin
        logic [NN-1:0] swn, wn, mid, par, mh;
        swn = r(0,3) | r(1,3) | r(2,3);
        wn  = r(1,3) | r(2,3);
        mh  = '0;
        mh[P +: P] = 5'b00110;
        par = r(0,2) | r(1,3) | r(2,0) | r(4,4);
        mid = r(0,2) | r(1,2) | r(2,3) | r(3,0) | r(4,0);

        // reset then single L->S request
        add(1, '0, 5'b00000, '0, 5'b00000, 5'b0);
        add(1, '0, 5'b00000, '0, 5'b00000, 5'b0);
        add(0, r(4,0), 5'b10000, c(0,4), 5'b00001, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b00001, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b00000, 5'b0);
        // S, W, N contend for E: S, then W, then N
        for (int k = 0; k < 3; k++) add(0, swn, 5'b00001, c(3,0), 5'b01000, 5'b0);
        add(0, wn, 5'b00000, '0, 5'b01000, 5'b0);
        add(0, wn, 5'b00000, '0, 5'b00000, 5'b0);
        for (int k = 0; k < 3; k++) add(0, wn, 5'b00010, c(3,1), 5'b01000, 5'b0);
        add(0, r(2,3), 5'b00000, '0, 5'b01000, 5'b0);
        add(0, r(2,3), 5'b00000, '0, 5'b00000, 5'b0);
        for (int k = 0; k < 3; k++) add(0, r(2,3), 5'b00100, c(3,2), 5'b01000, 5'b0);
        // ptr[E]=3: L wins over S, then pointer wraps to 0 so S beats W
        add(0, r(4,3) | r(0,3), 5'b00000, '0, 5'b01000, 5'b0);
        add(0, r(4,3) | r(0,3), 5'b00000, '0, 5'b00000, 5'b0);
        add(0, r(4,3) | r(0,3), 5'b10000, c(3,4), 5'b01000, 5'b0);
        add(0, r(0,3) | r(1,3), 5'b00000, '0, 5'b01000, 5'b0);
        add(0, r(0,3) | r(1,3), 5'b00000, '0, 5'b00000, 5'b0);
        add(0, r(0,3) | r(1,3), 5'b00001, c(3,0), 5'b01000, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b01000, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b00000, 5'b0);
        // illegal S->S, multi-hot W, legal N->E in the same cycle
        add(0, r(0,0) | mh | r(2,3), 5'b00100, c(3,2), 5'b01000, 5'b00011);
        add(0, '0, 5'b00000, '0, 5'b01000, 5'b00000);
        add(0, '0, 5'b00000, '0, 5'b00000, 5'b00000);
        // four parallel grants
        add(0, par, 5'b10111, c(2,0) | c(3,1) | c(0,2) | c(4,4), 5'b11101, 5'b0);
        // keep only W->E, then W retargets to L
        add(0, r(1,3), 5'b00010, c(3,1), 5'b11101, 5'b0);
        add(0, r(1,3), 5'b00010, c(3,1), 5'b01000, 5'b0);
        add(0, r(1,4), 5'b00000, '0, 5'b01000, 5'b0);
        add(0, r(1,4), 5'b00010, c(4,1), 5'b10000, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b10000, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b00000, 5'b0);
        // three grants, reset mid-operation, re-grant with pointers back at 0
        add(0, mid, 5'b01110, c(2,1) | c(3,2) | c(0,3), 5'b01101, 5'b0);
        add(1, mid, 5'b00000, '0, 5'b00000, 5'b0);
        add(0, mid, 5'b01101, c(2,0) | c(3,2) | c(0,3), 5'b01101, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b01101, 5'b0);
        add(0, '0, 5'b00000, '0, 5'b00000, 5'b0);

        rst = 1'b1;
        req = '0;
        for (int k = 0; k < tv.size(); k++) begin
            cyc(tv[k].rst, tv[k].req);
            if (k == 1) mon_en = 1'b1;
            check("ack",  k, NN'(ack),  NN'(tv[k].ack));
            check("cfg",  k, cfg,       tv[k].cfg);
            check("busy", k, NN'(busy), NN'(tv[k].busy));
            check("err",  k, NN'(err),  NN'(tv[k].err));
        end

        // Withdraw then immediately re-request W->W: re-grant lands on the
        // third edge after the withdrawal, never earlier.
        cyc(0, r(1,1));
        check("lat_grant", 100, NN'(ack), NN'(5'b00010));
        cyc(0, '0);
        check("lat_drop_ack", 101, NN'(ack), NN'(5'b00000));
        check("lat_drop_busy", 101, NN'(busy), NN'(5'b00010));
        cyc(0, r(1,1));
        check("lat_idle_ack", 102, NN'(ack), NN'(5'b00000));
        check("lat_idle_busy", 102, NN'(busy), NN'(5'b00000));
        cyc(0, r(1,1));
        check("lat_regrant", 103, cfg, c(1,1));
        cyc(0, '0);
        cyc(0, '0);
        check("lat_final_busy", 105, NN'(busy), NN'(5'b00000));

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clos_cm_sync_alloc.md
Name: clos_cm_sync_alloc

Overview:
- Synchronous central-module (CM) port allocator for the clocked variant of the Clos SDM router.
- Each of P input-side links (S, W, N, E, L order) presents a one-hot request for one of P output links.
- Each output is granted to at most one input by a per-output round-robin arbiter. The grant is held until the requester withdraws.
- Drives the CM crossbar configuration and per-input acknowledges. Sits between the IM allocators and the CM switch, one instance per CM.

Parameters:
- P, 5, number of input links and of output links (index 0..4 = S,W,N,E,L).
- ALLOW, 25'h1FF_FFFF, turn-legality mask; bit i*P+o = 1 permits input i to use output o.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- req  input  P*P  request; bits [i*P +: P] are input i's target vector (one-hot or zero).
- ack  output  P  ack[i]=1 while input i holds an output grant.
- cfg  output  P*P  crossbar config; bits [o*P +: P] one-hot select of the input driving output o, zero if none.
- busy  output  P  busy[o]=1 while output o is GRANTED or RECOVER.
- err  output  P  err[i]=1 for the cycle after input i presented a multi-hot or illegal request.

Behaviour:
- All outputs are registered. Reset: ack=0, cfg=0, busy=0, err=0. All outputs enter IDLE and all RR pointers are set to 0. Reset asserted mid-grant clears everything at that edge with no RECOVER cycle.
- Request validity per cycle:
  - valid(i) = req_i is one-hot AND (req_i & ALLOW_i) != 0.
  - Multi-hot or disallowed nonzero req_i gives err[i]=1 on the next edge. That input is never considered for arbitration that cycle.
  - An already-granted input that goes invalid is treated as a release.
- Per-output state machine (encoding is free):
  - IDLE -> GRANTED(k) when at least one valid input targets o and is not already granted elsewhere. k is the first such input searching from ptr[o] upward, modulo P. At that edge: cfg[o*P+k]=1, ack[k]=1, busy[o]=1, ptr[o]=(k+1) mod P.
  - GRANTED(k) stays while req_k == onehot(o).
  - GRANTED(k) -> RECOVER when req_k != onehot(o), sampled at the edge. At that edge cfg[o] clears, ack[k] clears and busy[o] stays 1.
  - RECOVER -> IDLE unconditionally after 1 cycle. No grant is issued from RECOVER; this models return-to-zero.
- Latency:
  - Request to ack/cfg: 1 clock from the edge sampling the request.
  - Withdrawal to ack low: 1 clock.
  - Withdrawal to earliest re-grant of the same output: 3 edges (RECOVER, then IDLE arbitration).
- An input holds at most one grant. A held grant shields the input from other outputs' arbitration, though its request is one-hot anyway.
- Simultaneous requests to one output: exactly one wins per RR. Losers keep ack=0 and must keep requesting; there is no queueing.
- Different outputs arbitrate independently in the same cycle; multiple grants per cycle are allowed.
- Pointer update happens only on a grant. Wrap: ptr=P-1 with a grant to P-1 gives ptr 0.
- Invariants (assertable):
  - Each cfg slice has popcount <= 1.
  - Each input appears in at most one cfg slice.
  - ack[i] equals the OR over o of cfg[o*P+i].
  - busy[o]=0 implies the cfg slice is 0.

Test Plan:
- Reset then single request: rst=1 for 2 cycles. Then req[L]=5'b00001 (L->S). Next edge: cfg[S]=5'b10000, ack=5'b10000, busy[0]=1. Drop req: ack=0 after 1 edge, busy[0]=0 after 2 edges.
- Contention and round-robin: S, W and N each request E continuously. Grants to E go S, then W, then N, each held 3 cycles then released. Each handover shows exactly one RECOVER cycle with cfg[E]=0 and busy[E]=1. ptr[E] wraps 3->0 correctly after a grant to L.
- Illegal and multi-hot requests: ALLOW clears S->S. req[S]=5'b00001 gives err[0]=1 and no grant. req[W]=5'b00110 gives err[1]=1 and no grant. Legal requests in the same cycle are granted normally.
- Parallel grants: S->N, W->E, N->S and L->L are requested in the same cycle. All four are granted on one edge; ack=5'b10111 and cfg has four one-hot slices.
- Retarget while granted: W is granted E, then switches req to L. E goes to RECOVER and W's ack drops. W's new L request is granted 1 edge later, provided L is IDLE.
- Reset mid-operation: 3 grants active, then assert rst for 1 cycle. All outputs are 0 at that edge and ptrs read 0. Requests held through reset are re-granted on the first edge after rst deasserts, with the lowest index winning.
